ibex_mem_arbiter: RTL and testbench
===================================

IBEX_MEM_ARBITER -- requirements
Module: ibex_mem_arbiter

Interface
REQ-001 SHALL have parameter MaxOutstanding, default 2, giving the outstanding-transaction depth (legal range 1..4).
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state is on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1, the asynchronous active-low reset.
REQ-004 SHALL have port instr_req_i, input, 1, the instruction-side request.
REQ-005 SHALL have port instr_gnt_o, output, 1, the instruction-side grant.
REQ-006 SHALL have port instr_addr_i, input, 32, the instruction fetch address.
REQ-007 SHALL have port instr_rvalid_o, output, 1, the instruction response valid.
REQ-008 SHALL have port instr_rdata_o, output, 32, the instruction read data.
REQ-009 SHALL have port instr_err_o, output, 1, the instruction response error.
REQ-010 SHALL have port data_req_i, input, 1, the data-side request.
REQ-011 SHALL have port data_gnt_o, output, 1, the data-side grant.
REQ-012 SHALL have port data_we_i, input, 1, the data write enable.
REQ-013 SHALL have port data_be_i, input, 4, the data byte enables.
REQ-014 SHALL have port data_addr_i, input, 32, the data address.
REQ-015 SHALL have port data_wdata_i, input, 32, the data write data.
REQ-016 SHALL have port data_rvalid_o, output, 1, the data response valid.
REQ-017 SHALL have port data_rdata_o, output, 32, the data read data.
REQ-018 SHALL have port data_err_o, output, 1, the data response error.
REQ-019 SHALL have port mem_req_o, output, 1, the shared-port request.
REQ-020 SHALL have port mem_gnt_i, input, 1, the shared-port grant.
REQ-021 SHALL have ports mem_we_o (output, 1), mem_be_o (output, 4), mem_addr_o (output, 32) and mem_wdata_o (output, 32), the shared-port request payload.
REQ-022 SHALL have ports mem_rvalid_i (input, 1), mem_rdata_i (input, 32) and mem_err_i (input, 1), the shared-port response.

Function
REQ-023 SHALL drive mem_req_o = (instr_req_i | data_req_i) & ~full & rst_ni, where full means the registered count equals MaxOutstanding.
REQ-024 SHALL select a winner combinationally: data beats instruction under fixed priority (see REQ-035/036).
REQ-025 SHALL mux the winner's payload onto mem_*; an instruction winner drives we=0, be=4'hF, wdata=0.
REQ-026 SHALL assert the winner's gnt_o = mem_req_o & mem_gnt_i, and assert the loser's gnt_o never in that cycle; grant adds 0 cycles of latency.
REQ-027 SHALL lock the winner while mem_req_o=1 and mem_gnt_i=0, and release the lock on the accepting cycle.
REQ-028 SHALL keep the winner locked if its request drops while locked (protocol violation); mem_req_o then stays high on the remaining requester only after the lock releases.
REQ-029 SHALL push the winner ID into the ID FIFO on every accepted grant.
REQ-030 SHALL pop the FIFO head on mem_rvalid_i and route rvalid to the head ID; rdata/err forward combinationally, 0 cycles added.
REQ-031 SHALL drive rdata_o = mem_rdata_i to both sides; err_o = mem_err_i & rvalid_o.
REQ-032 SHALL, on simultaneous push and pop, leave the count unchanged; when full, SHALL block grants even if a pop occurs in the same cycle.
REQ-033 SHALL ignore mem_rvalid_i while the FIFO is empty: both rvalid_o stay low and the count stays 0.
REQ-034 SHALL wrap the FIFO pointers modulo MaxOutstanding.

Configuration
REQ-035 SHALL, with IBEX_MEM_ARB_RR_EN defined, use round-robin: on a conflict, the side not granted last wins, and last_gnt updates on each accepted grant.
REQ-036 SHALL, without IBEX_MEM_ARB_RR_EN, use fixed data priority; last_gnt SHALL NOT exist.

Reset
REQ-037 SHALL, while rst_ni=0, clear the FIFO and count and the lock, set last_gnt=instr, and hold mem_req_o, both gnt_o and both rvalid_o at 0.
REQ-038 SHALL discard outstanding IDs on a mid-transfer reset; a stale mem_rvalid_i arriving after reset is handled per REQ-033.

Structure
REQ-039 SHALL place enum arb_id_e {ARB_INSTR, ARB_DATA} and the MaxOutstanding default in package ibex_mem_arb_pkg.
REQ-040 SHALL implement the ID FIFO as sub-module ibex_mem_arb_idfifo (push, pop, id in/out, count, full, empty).

Verification
REQ-041 SHALL test: both requests in one cycle with mem_gnt_i=1, fixed mode -> data_gnt_o=1, instr_gnt_o=0, mem_addr_o=data_addr_i.
REQ-042 SHALL test: instr request stalled 3 cycles (mem_gnt_i=0), data request arrives in cycle 2 -> mem_addr_o stays instr_addr_i until the grant.
REQ-043 SHALL test: grants for instr then data, then 2 mem_rvalid_i pulses -> instr_rvalid_o then data_rvalid_o, each in its pulse cycle.
REQ-044 SHALL test: MaxOutstanding=2 with 2 outstanding and a new request -> mem_req_o=0 until the first rvalid, then 1 the next cycle.
REQ-045 SHALL test: RR build with both requesters held high for 4 grants -> grants alternate data, instr, data, instr.
REQ-046 SHALL test: reset pulse with 1 outstanding, then mem_rvalid_i=1 -> both rvalid_o remain 0.

Source files
------------

// File: rtl/ibex_mem_arb_pkg.sv
// Shared types for the Ibex instruction/data memory arbiter.
// Requester IDs, lock states and the outstanding-depth default.
package ibex_mem_arb_pkg;

    typedef enum logic {
        ARB_INSTR = 1'b0,
        ARB_DATA  = 1'b1
    } arb_id_e;

    typedef enum logic {
        LOCK_IDLE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_e;

    localparam int unsigned MaxOutstandingDefault = 2;
    localparam int unsigned CountWidth = 3;

    function automatic arb_id_e other_id(arb_id_e id);
        return (id == ARB_DATA) ? ARB_INSTR : ARB_DATA;
    endfunction

endpackage

// File: rtl/ibex_mem_arb_idfifo.sv
// Requester-ID FIFO: remembers which side owns each outstanding
// transaction so responses can be routed back in order.
module ibex_mem_arb_idfifo
    import ibex_mem_arb_pkg::*;
#(
    parameter int unsigned Depth = MaxOutstandingDefault
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  id_in,
    output logic                  id_out,
    output logic [CountWidth-1:0] count,
    output logic                  full,
    output logic                  empty
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

    logic [Depth-1:0]      slots;
    logic [PtrW-1:0]       wptr;
    logic [PtrW-1:0]       rptr;
    logic [CountWidth-1:0] cnt_q;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (cnt_q == CountWidth'(Depth));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign id_out  = slots[rptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slots <= '0;
            wptr  <= '0;
            rptr  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                slots[wptr] <= id_in;
                wptr        <= (wptr == LastPtr) ? '0 : wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= (rptr == LastPtr) ? '0 : rptr + 1'b1;
            end
            // A same-cycle push and pop leaves the occupancy unchanged.
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ibex_mem_arbiter.sv
// Two-into-one memory port arbiter for Ibex instruction and data sides.
// Define IBEX_MEM_ARB_RR_EN for round-robin; default is fixed data priority.
module ibex_mem_arbiter
    import ibex_mem_arb_pkg::*;
#(
    parameter int unsigned MaxOutstanding = MaxOutstandingDefault
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    input  logic [31:0] instr_addr_i,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,

    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,

    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i
);

    lock_state_e           lock_q;
    arb_id_e               lock_id_q;
    arb_id_e               pick;
    arb_id_e               winner;
    arb_id_e               head_id;
    logic                  accept;
    logic                  rsp_valid;
    logic                  fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CountWidth-1:0] fifo_count;
    logic                  unused_count;

`ifdef IBEX_MEM_ARB_RR_EN
    arb_id_e last_gnt_q;
`endif

    always_comb begin
        pick = ARB_INSTR;
        if (data_req_i && instr_req_i) begin
`ifdef IBEX_MEM_ARB_RR_EN
            pick = other_id(last_gnt_q);
`else
            pick = ARB_DATA;
`endif
        end else if (data_req_i) begin
            pick = ARB_DATA;
        end
    end

    // A stalled request keeps its owner until the memory accepts it.
    assign winner = (lock_q == LOCK_HELD) ? lock_id_q : pick;

    assign mem_req_o = (instr_req_i | data_req_i) & ~fifo_full & rst_ni;
    assign accept    = mem_req_o & mem_gnt_i;

    assign instr_gnt_o = accept & (winner == ARB_INSTR);
    assign data_gnt_o  = accept & (winner == ARB_DATA);

    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = 4'hF;
        mem_addr_o  = instr_addr_i;
        mem_wdata_o = '0;
        if (winner == ARB_DATA) begin
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q    <= LOCK_IDLE;
            lock_id_q <= ARB_INSTR;
        end else begin
            unique case (lock_q)
                LOCK_IDLE: begin
                    if (mem_req_o && !mem_gnt_i) begin
                        lock_q    <= LOCK_HELD;
                        lock_id_q <= pick;
                    end
                end
                LOCK_HELD: begin
                    if (accept) begin
                        lock_q <= LOCK_IDLE;
                    end
                end
                default: lock_q <= LOCK_IDLE;
            endcase
        end
    end

`ifdef IBEX_MEM_ARB_RR_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_gnt_q <= ARB_INSTR;
        end else if (accept) begin
            last_gnt_q <= winner;
        end
    end
`endif

    ibex_mem_arb_idfifo #(
        .Depth (MaxOutstanding)
    ) u_idfifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (accept),
        .pop    (rsp_valid),
        .id_in  (winner),
        .id_out (fifo_head),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign unused_count = ^fifo_count;

    // Responses with nothing outstanding are stale and dropped.
    assign rsp_valid = mem_rvalid_i & ~fifo_empty & rst_ni;
    assign head_id   = arb_id_e'(fifo_head);

    assign instr_rvalid_o = rsp_valid & (head_id == ARB_INSTR);
    assign data_rvalid_o  = rsp_valid & (head_id == ARB_DATA);

    assign instr_rdata_o = mem_rdata_i;
    assign data_rdata_o  = mem_rdata_i;
    assign instr_err_o   = mem_err_i & instr_rvalid_o;
    assign data_err_o    = mem_err_i & data_rvalid_o;

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Scoreboard bench for ibex_mem_arbiter: stimulus queues expected
// grants/responses, a negedge monitor pops and compares them.
module tb_ibex_mem_arbiter;
    import ibex_mem_arb_pkg::*;

    logic        clk_i;
    logic        rst_ni;
    logic        instr_req_i;
    logic        instr_gnt_o;
    logic [31:0] instr_addr_i;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic        data_req_i;
    logic        data_gnt_o;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_err_i;

    typedef struct {
        arb_id_e     id;
        logic [31:0] addr;
    } gnt_t;

    typedef struct {
        arb_id_e     id;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    gnt_t exp_gnt[$];
    rsp_t exp_rsp[$];
    gnt_t mon_g;
    rsp_t mon_r;
    int   checks = 0;
    int   errors = 0;

    arb_id_e order [4];

    ibex_mem_arbiter #(
        .MaxOutstanding (2)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .instr_req_i    (instr_req_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_addr_i   (instr_addr_i),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .instr_err_o    (instr_err_o),
        .data_req_i     (data_req_i),
        .data_gnt_o     (data_gnt_o),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .data_err_o     (data_err_o),
        .mem_req_o      (mem_req_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .mem_err_i      (mem_err_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        instr_req_i  = 1'b0;
        data_req_i   = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_err_i    = 1'b0;
    endtask

    always @(negedge clk_i) begin
        if (instr_gnt_o || data_gnt_o) begin
            chk1("gnt_exclusive", instr_gnt_o & data_gnt_o, 1'b0);
            if (exp_gnt.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL gnt_unexpected: instr_gnt=%b data_gnt=%b at %0t",
                         instr_gnt_o, data_gnt_o, $time);
            end else begin
                mon_g = exp_gnt.pop_front();
                chk1("gnt_id_data", data_gnt_o, mon_g.id == ARB_DATA);
                chk32("gnt_addr", mem_addr_o, mon_g.addr);
            end
        end
        if (instr_rvalid_o || data_rvalid_o) begin
            chk1("rsp_exclusive", instr_rvalid_o & data_rvalid_o, 1'b0);
            if (exp_rsp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: instr_rvalid=%b data_rvalid=%b at %0t",
                         instr_rvalid_o, data_rvalid_o, $time);
            end else begin
                mon_r = exp_rsp.pop_front();
                chk1("rsp_id_data", data_rvalid_o, mon_r.id == ARB_DATA);
                chk32("rsp_rdata",
                      (mon_r.id == ARB_DATA) ? data_rdata_o : instr_rdata_o,
                      mon_r.rdata);
                chk1("rsp_err",
                     (mon_r.id == ARB_DATA) ? data_err_o : instr_err_o,
                     mon_r.err);
                chk1("rsp_err_other",
                     (mon_r.id == ARB_DATA) ? instr_err_o : data_err_o,
                     1'b0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef IBEX_MEM_ARB_RR_EN
        order = '{ARB_DATA, ARB_INSTR, ARB_DATA, ARB_INSTR};
`else
        order = '{ARB_DATA, ARB_DATA, ARB_DATA, ARB_DATA};
`endif
        rst_ni       = 1'b0;
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_0000;
        data_req_i   = 1'b1;
        data_we_i    = 1'b0;
        data_be_i    = 4'hF;
        data_addr_i  = 32'h0000_0000;
        data_wdata_i = 32'h0;
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0;
        mem_err_i    = 1'b1;

        // Outputs held low in reset despite active inputs
        repeat (2) @(posedge clk_i);
        #1;
        chk1("rst_mem_req", mem_req_o, 1'b0);
        chk1("rst_instr_gnt", instr_gnt_o, 1'b0);
        chk1("rst_data_gnt", data_gnt_o, 1'b0);
        chk1("rst_instr_rvalid", instr_rvalid_o, 1'b0);
        chk1("rst_data_rvalid", data_rvalid_o, 1'b0);
        idle();
        step();
        rst_ni = 1'b1;
        step();
        chk1("idle_mem_req", mem_req_o, 1'b0);

        // Both request, memory grants: data wins
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_1000;
        data_req_i   = 1'b1;
        data_addr_i  = 32'h2000_0040;
        data_we_i    = 1'b1;
        data_be_i    = 4'h3;
        data_wdata_i = 32'hdead_beef;
        mem_gnt_i    = 1'b1;
        exp_gnt.push_back('{ARB_DATA, 32'h2000_0040});
        #2;
        chk1("conflict_mem_req", mem_req_o, 1'b1);
        chk1("conflict_instr_gnt", instr_gnt_o, 1'b0);
        chk1("conflict_data_gnt", data_gnt_o, 1'b1);
        chk32("conflict_addr", mem_addr_o, 32'h2000_0040);
        chk1("conflict_we", mem_we_o, 1'b1);
        chk32("conflict_be", {28'b0, mem_be_o}, 32'h3);
        chk32("conflict_wdata", mem_wdata_o, 32'hdead_beef);
        step();
        idle();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1111_0001;
        exp_rsp.push_back('{ARB_DATA, 32'h1111_0001, 1'b0});
        step();
        idle();

        // Instruction stalled three cycles, data arrives in cycle two
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_1004;
        #2;
        chk1("stall_mem_req", mem_req_o, 1'b1);
        chk32("stall_addr_c1", mem_addr_o, 32'h0000_1004);
        step();
        data_req_i   = 1'b1;
        data_addr_i  = 32'h2000_0080;
        data_we_i    = 1'b0;
        data_be_i    = 4'hF;
        #2;
        chk32("stall_addr_c2", mem_addr_o, 32'h0000_1004);
        step();
        #2;
        chk32("stall_addr_c3", mem_addr_o, 32'h0000_1004);
        step();
        mem_gnt_i = 1'b1;
        exp_gnt.push_back('{ARB_INSTR, 32'h0000_1004});
        #2;
        chk32("stall_grant_addr", mem_addr_o, 32'h0000_1004);
        chk1("instr_payload_we", mem_we_o, 1'b0);
        chk32("instr_payload_be", {28'b0, mem_be_o}, 32'hF);
        chk32("instr_payload_wdata", mem_wdata_o, 32'h0);
        step();
        instr_req_i = 1'b0;
        exp_gnt.push_back('{ARB_DATA, 32'h2000_0080});
        #2;
        chk32("after_lock_addr", mem_addr_o, 32'h2000_0080);
        step();
        idle();

        // Two outstanding: request blocked until the first response
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_1008;
        mem_gnt_i    = 1'b1;
        #2;
        chk1("full_mem_req_c1", mem_req_o, 1'b0);
        step();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1111_0002;
        mem_err_i    = 1'b1;
        exp_rsp.push_back('{ARB_INSTR, 32'h1111_0002, 1'b1});
        #2;
        chk1("full_pop_mem_req", mem_req_o, 1'b0);
        step();
        mem_rvalid_i = 1'b0;
        mem_err_i    = 1'b0;
        exp_gnt.push_back('{ARB_INSTR, 32'h0000_1008});
        #2;
        chk1("after_pop_mem_req", mem_req_o, 1'b1);
        step();
        idle();

        // Responses return in grant order
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1111_0003;
        exp_rsp.push_back('{ARB_DATA, 32'h1111_0003, 1'b0});
        step();
        mem_rvalid_i = 1'b0;
        step();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1111_0004;
        exp_rsp.push_back('{ARB_INSTR, 32'h1111_0004, 1'b0});
        step();
        idle();

        // Same-cycle push and pop keeps the count
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_100C;
        mem_gnt_i    = 1'b1;
        exp_gnt.push_back('{ARB_INSTR, 32'h0000_100C});
        step();
        idle();
        data_req_i   = 1'b1;
        data_addr_i  = 32'h2000_00C0;
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1111_0005;
        exp_gnt.push_back('{ARB_DATA, 32'h2000_00C0});
        exp_rsp.push_back('{ARB_INSTR, 32'h1111_0005, 1'b0});
        step();
        idle();
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_1010;
        mem_gnt_i    = 1'b1;
        exp_gnt.push_back('{ARB_INSTR, 32'h0000_1010});
        #2;
        chk1("pushpop_count1", mem_req_o, 1'b1);
        step();
        #2;
        chk1("pushpop_now_full", mem_req_o, 1'b0);
        idle();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1111_0006;
        exp_rsp.push_back('{ARB_DATA, 32'h1111_0006, 1'b0});
        step();
        idle();

        // Reset with one outstanding discards it
        rst_ni       = 1'b0;
        mem_rvalid_i = 1'b1;
        #2;
        chk1("midrst_instr_rvalid", instr_rvalid_o, 1'b0);
        step();
        rst_ni = 1'b1;
        #2;
        chk1("stale_instr_rvalid", instr_rvalid_o, 1'b0);
        chk1("stale_data_rvalid", data_rvalid_o, 1'b0);
        step();
        #2;
        chk1("stale_instr_rvalid_2", instr_rvalid_o, 1'b0);
        chk1("stale_mem_req", mem_req_o, 1'b0);
        step();
        idle();

        // Both held high for four grants
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_1100;
        data_req_i   = 1'b1;
        data_addr_i  = 32'h2000_0100;
        data_we_i    = 1'b0;
        data_be_i    = 4'hF;
        mem_gnt_i    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_gnt.push_back('{order[i],
                (order[i] == ARB_DATA) ? 32'h2000_0100 : 32'h0000_1100});
            mem_rvalid_i = 1'b0;
            if (i > 0) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = 32'h2222_0000 + 32'(i);
                exp_rsp.push_back('{order[i-1], 32'h2222_0000 + 32'(i), 1'b0});
            end
            step();
        end
        idle();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h2222_0004;
        exp_rsp.push_back('{order[3], 32'h2222_0004, 1'b0});
        step();
        idle();
        step();
        step();

        chk32("gnt_queue_drained", 32'(exp_gnt.size()), 32'h0);
        chk32("rsp_queue_drained", 32'(exp_rsp.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
